// File: rtl/vec_addsub_seq.sv
// vec_addsub_seq: multi-cycle SIMD add/subtract over a VLEN-bit vector.
// One 32-bit slice is processed per cycle by four chained 8-bit adders.
// The carry chain is cut at element boundaries selected by the element width.
module vec_addsub_seq #(
  parameter int VLEN = 128,
  parameter int LANE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              op_i,
  input  logic [1:0]        sew_i,
  input  logic [VLEN-1:0]   vs1_i,
  input  logic [VLEN-1:0]   vs2_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [VLEN-1:0]   result_o,
  output logic [VLEN/8-1:0] carry_o
);

  localparam int NSL = VLEN / LANE;
  localparam int NB  = LANE / 8;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic                r_op;
  logic [1:0]          r_sew;
  logic [VLEN-1:0]     r_vs1;
  logic [VLEN-1:0]     r_vs2;
  logic [VLEN-1:0]     r_result;
  logic [VLEN/8-1:0]   r_carry;
  logic                r_ready;
  logic                r_done;
  logic [LANE-1:0]     w_a;
  logic [LANE-1:0]     w_b;
  logic [LANE-1:0]     w_sum;
  logic [NB-1:0]       w_cflag;

  // Byte j is the lowest byte of an element: its carry-in is the operation carry-in.
  function automatic logic elem_first(input logic [1:0] j, input logic [1:0] sew);
    logic f;
    case (sew)
      2'b00:   f = 1'b1;
      2'b01:   f = (j[0] == 1'b0);
      default: f = (j == 2'd0);
    endcase
    return f;
  endfunction

  // Byte j is the most significant byte of an element: it reports the element carry.
  function automatic logic elem_msb(input logic [1:0] j, input logic [1:0] sew);
    logic f;
    case (sew)
      2'b00:   f = 1'b1;
      2'b01:   f = (j[0] == 1'b1);
      default: f = (j == 2'd3);
    endcase
    return f;
  endfunction

  // 8-bit adder with carry-in; bit 8 of the result is the carry-out.
  function automatic logic [8:0] byte_add(input logic [7:0] a, input logic [7:0] b,
                                          input logic cin);
    return {1'b0, a} + {1'b0, b} + {8'd0, cin};
  endfunction

  // Select the current slice of both captured operands.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int s = 0; s < NSL; s++) begin
      w_a = w_a | (r_vs2[s*LANE +: LANE] & {LANE{r_cnt == CW'(s)}});
      w_b = w_b | (r_vs1[s*LANE +: LANE] & {LANE{r_cnt == CW'(s)}});
    end
  end

  // Four byte adders; subtract feeds ~vs1 with carry-in 1, carries stop at element edges.
  always_comb begin : slice_alu
    logic [LANE-1:0] v_b;
    logic [8:0]      v_s;
    logic            v_c;
    logic            v_cin;
    w_sum   = '0;
    w_cflag = '0;
    v_b     = r_op ? ~w_b : w_b;
    v_c     = 1'b0;
    v_s     = 9'd0;
    v_cin   = 1'b0;
    for (int j = 0; j < NB; j++) begin
      v_cin           = elem_first(2'(j), r_sew) ? r_op : v_c;
      v_s             = byte_add(w_a[8*j +: 8], v_b[8*j +: 8], v_cin);
      w_sum[8*j +: 8] = v_s[7:0];
      v_c             = v_s[8];
      w_cflag[j]      = elem_msb(2'(j), r_sew) & v_c;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: accept in IDLE, walk all slices in BUSY, one DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next = BUSY;
        end else begin
          w_next = IDLE;
        end
      end
      BUSY: begin
        if (r_cnt == LAST_SLICE) begin
          w_next = DONE;
        end else begin
          w_next = BUSY;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, slice counter and slice-wise result/carry write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= 1'b0;
      r_sew    <= 2'b00;
      r_vs1    <= '0;
      r_vs2    <= '0;
      r_result <= '0;
      r_carry  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_op  <= op_i;
            r_sew <= sew_i;
            r_vs1 <= vs1_i;
            r_vs2 <= vs2_i;
            r_cnt <= '0;
          end
        end
        BUSY: begin
          for (int s = 0; s < NSL; s++) begin
            if (r_cnt == CW'(s)) begin
              r_result[s*LANE +: LANE] <= w_sum;
              r_carry[s*NB +: NB]      <= w_cflag;
            end
          end
          if (r_cnt == LAST_SLICE) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  // Registered handshake flags decoded from the upcoming state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_next == IDLE);
      r_done  <= (w_next == DONE);
    end
  end

  assign ready_o  = r_ready;
  assign done_o   = r_done;
  assign result_o = r_result;
  assign carry_o  = r_carry;

endmodule

// File: tb/tb_vec_addsub_seq.sv
// Self-checking bench for vec_addsub_seq: directed corner cases plus
// randomized operations compared against an element-level arithmetic model.
module tb_vec_addsub_seq;

  localparam int VLEN = 128;
  localparam int NSL  = VLEN / 32;

  logic              clk;
  logic              rst_n;
  logic              start_i;
  logic              op_i;
  logic [1:0]        sew_i;
  logic [VLEN-1:0]   vs1_i;
  logic [VLEN-1:0]   vs2_i;
  logic              ready_o;
  logic              done_o;
  logic [VLEN-1:0]   result_o;
  logic [VLEN/8-1:0] carry_o;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  vec_addsub_seq #(.VLEN(VLEN), .LANE(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .sew_i    (sew_i),
    .vs1_i    (vs1_i),
    .vs2_i    (vs2_i),
    .ready_o  (ready_o),
    .done_o   (done_o),
    .result_o (result_o),
    .carry_o  (carry_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] v;
    v = '0;
    for (int i = 0; i < VLEN / 32; i++) v = (v << 32) | VLEN'($urandom);
    return v;
  endfunction

  // Element-level reference: plain modular add/sub per element, carry = no overflow/borrow.
  function automatic void ref_model(input bit op, input logic [1:0] sew,
                                    input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2,
                                    output logic [VLEN-1:0] r, output logic [VLEN/8-1:0] c);
    int ew;
    longint unsigned mask, a, b, res;
    bit cy;
    ew   = (sew == 2'b00) ? 8 : (sew == 2'b01) ? 16 : 32;
    mask = (64'd1 << ew) - 64'd1;
    r = '0;
    c = '0;
    for (int e = 0; e < VLEN / ew; e++) begin
      a = 64'(v2 >> (e * ew)) & mask;
      b = 64'(v1 >> (e * ew)) & mask;
      if (op) begin
        res = (a - b) & mask;
        cy  = (a >= b);
      end else begin
        res = (a + b) & mask;
        cy  = ((a + b) > mask);
      end
      r = r | (VLEN'(res) << (e * ew));
      c[(e * ew) / 8 + ew / 8 - 1] = cy;
    end
  endfunction

  // Run one operation from IDLE; optionally wiggle inputs (incl. start_i) while busy.
  task automatic run_op(input string tag, input bit op, input logic [1:0] sew,
                        input logic [VLEN-1:0] v1, input logic [VLEN-1:0] v2,
                        input logic [VLEN-1:0] exp_r, input logic [VLEN/8-1:0] exp_c,
                        input bit noisy);
    int  lat;
    bit  got;
    start_i = 1'b1;
    op_i    = op;
    sew_i   = sew;
    vs1_i   = v1;
    vs2_i   = v2;
    lat     = 0;
    got     = 1'b0;
    for (int t = 1; t <= 20 && !got; t++) begin
      tick();
      lat = t;
      if (done_o) begin
        got = 1'b1;
      end else begin
        check({tag, "_ready_busy"}, VLEN'(ready_o), VLEN'(0));
        if (noisy) begin
          start_i = 1'($urandom);
          op_i    = 1'($urandom);
          sew_i   = 2'($urandom);
          vs1_i   = rand_vec();
          vs2_i   = rand_vec();
        end else begin
          start_i = 1'b0;
        end
      end
    end
    start_i = 1'b0;
    check({tag, "_done_seen"}, VLEN'(got), VLEN'(1));
    check({tag, "_latency"}, VLEN'(lat), VLEN'(NSL + 1));
    check({tag, "_result"}, result_o, exp_r);
    check({tag, "_carry"}, VLEN'(carry_o), VLEN'(exp_c));
    tick();
    check({tag, "_done_pulse"}, VLEN'(done_o), VLEN'(0));
    check({tag, "_ready_idle"}, VLEN'(ready_o), VLEN'(1));
    check({tag, "_result_hold"}, result_o, exp_r);
  endtask

  initial begin : main
    logic [VLEN-1:0]   v1, v2, er, er2;
    logic [VLEN/8-1:0] ec, ec2;
    logic [VLEN-1:0]   rv;
    bit                op;
    logic [1:0]        sew;
    int                ndone;

    rst_n   = 1'b0;
    start_i = 1'b0;
    op_i    = 1'b0;
    sew_i   = 2'b00;
    vs1_i   = '0;
    vs2_i   = '0;

    // Reset state
    #12;
    check("rst_ready", VLEN'(ready_o), VLEN'(1));
    check("rst_done", VLEN'(done_o), VLEN'(0));
    check("rst_result", result_o, '0);
    check("rst_carry", VLEN'(carry_o), '0);
    rst_n = 1'b1;

    // SEW=8 add, 0xFF + 0x01 per byte: wraps to 0, every byte carries
    v1 = {VLEN/8{8'h01}};
    v2 = {VLEN/8{8'hFF}};
    run_op("sew8_add_wrap", 1'b0, 2'b00, v1, v2, '0, {VLEN/8{1'b1}}, 1'b0);

    // SEW=16 sub, 0 - 1 per element: 0xFFFF with borrow (carry flag 0)
    v1 = {VLEN/16{16'h0001}};
    v2 = '0;
    run_op("sew16_sub_borrow", 1'b1, 2'b01, v1, v2, {VLEN/16{16'hFFFF}}, '0, 1'b0);

    // SEW=32 add, carry ripples inside the element
    v1 = {VLEN/32{32'h0000_0001}};
    v2 = {VLEN/32{32'h0000_FFFF}};
    run_op("sew32_add_ripple", 1'b0, 2'b10, v1, v2, {VLEN/32{32'h0001_0000}}, '0, 1'b0);

    // Same operands with SEW=8: carry stops at each byte
    run_op("sew8_add_cut", 1'b0, 2'b00, v1, v2, {VLEN/32{32'h0000_FF00}},
           {VLEN/32{4'b0001}}, 1'b0);

    // SEW=16 add with carry out of the high byte of each element
    v1 = {VLEN/16{16'h0001}};
    v2 = {VLEN/16{16'hFFFF}};
    run_op("sew16_add_wrap", 1'b0, 2'b01, v1, v2, '0, {VLEN/16{2'b10}}, 1'b0);

    // sew=11 behaves exactly as sew=10
    v1 = rand_vec();
    v2 = rand_vec();
    ref_model(1'b1, 2'b10, v1, v2, er, ec);
    run_op("sew11_as_32", 1'b1, 2'b11, v1, v2, er, ec, 1'b0);

    // start_i held high: accept every 6th edge, one done pulse per op
    v1 = rand_vec();
    v2 = rand_vec();
    ref_model(1'b0, 2'b01, v1, v2, er, ec);
    start_i = 1'b1;
    op_i    = 1'b0;
    sew_i   = 2'b01;
    vs1_i   = v1;
    vs2_i   = v2;
    ndone   = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check($sformatf("hold_done_t%0d", t), VLEN'(done_o), VLEN'(t == 5 || t == 11));
      check($sformatf("hold_ready_t%0d", t), VLEN'(ready_o), VLEN'(t == 6 || t == 12));
      if (done_o) begin
        ndone++;
        check($sformatf("hold_result_t%0d", t), result_o, er);
      end
    end
    start_i = 1'b0;
    check("hold_done_count", VLEN'(ndone), VLEN'(2));
    tick();

    // Reset in the middle of BUSY aborts the op with no done pulse
    v1 = rand_vec();
    v2 = rand_vec();
    start_i = 1'b1;
    op_i    = 1'b1;
    sew_i   = 2'b00;
    vs1_i   = v1;
    vs2_i   = v2;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_ready", VLEN'(ready_o), VLEN'(1));
    check("abort_done", VLEN'(done_o), VLEN'(0));
    check("abort_result", result_o, '0);
    check("abort_carry", VLEN'(carry_o), '0);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (done_o) ndone++;
    end
    check("abort_no_done", VLEN'(ndone), VLEN'(0));
    check("abort_idle_ready", VLEN'(ready_o), VLEN'(1));
    ref_model(1'b1, 2'b00, v1, v2, er, ec);
    run_op("after_abort", 1'b1, 2'b00, v1, v2, er, ec, 1'b0);

    // Randomized operations with noisy inputs during BUSY
    for (int i = 0; i < 30; i++) begin
      op  = 1'($urandom);
      sew = 2'($urandom);
      v1  = rand_vec();
      v2  = rand_vec();
      if ((i % 5) == 0) v1 = v2;
      ref_model(op, sew, v1, v2, er, ec);
      run_op($sformatf("rand%0d", i), op, sew, v1, v2, er, ec, 1'b1);
    end

    // Cross-check sew=11 against the model's sew=10 result
    v1 = rand_vec();
    v2 = rand_vec();
    ref_model(1'b0, 2'b10, v1, v2, er2, ec2);
    run_op("sew11_add", 1'b0, 2'b11, v1, v2, er2, ec2, 1'b0);
    rv = result_o;
    check("sew11_add_hold_after", rv, er2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vec_addsub_seq.md
VEC_ADDSUB_SEQ -- requirements
Module: vec_addsub_seq

Interface
REQ-001 SHALL have parameter VLEN, default 128, vector length in bits; legal values are multiples of 32, minimum 32.
REQ-002 SHALL have parameter LANE, default 32, slice width processed per cycle; fixed at 32.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start_i, input, 1, request to begin one vector operation.
REQ-006 SHALL have port op_i, input, 1, operation select: 0 = add, 1 = subtract.
REQ-007 SHALL have port sew_i, input, 2, element width select: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = 32-bit.
REQ-008 SHALL have port vs1_i, input, VLEN, first source vector.
REQ-009 SHALL have port vs2_i, input, VLEN, second source vector.
REQ-010 SHALL have port ready_o, output, 1, high when idle and able to accept start_i.
REQ-011 SHALL have port done_o, output, 1, single-cycle pulse marking result_o/carry_o valid.
REQ-012 SHALL have port result_o, output, VLEN, destination vector.
REQ-013 SHALL have port carry_o, output, VLEN/8, per-byte carry flags.

Function
REQ-014 SHALL implement states IDLE, BUSY, DONE; reset state IDLE.
REQ-015 In IDLE, ready_o SHALL be 1; in BUSY and DONE, ready_o SHALL be 0.
REQ-016 start_i sampled high in IDLE SHALL capture vs1_i, vs2_i, op_i and sew_i into internal registers, clear slice counter to 0, and enter BUSY next cycle.
REQ-017 start_i in BUSY or DONE SHALL be ignored; it SHALL not alter captured operands or state.
REQ-018 Inputs vs1_i, vs2_i, op_i, sew_i SHALL be don't-care after the accept cycle.
REQ-019 In BUSY, each cycle SHALL process captured slice k (bits 32k+31:32k) and write it to result register slice k.
REQ-020 Slice processing SHALL use four 8-bit byte adders; each byte's carry-in SHALL be the lower byte's carry-out when that byte is not the lowest byte of an element, else the operation carry-in.
REQ-021 Element boundaries SHALL be: SEW=8, every byte; SEW=16, bytes 0 and 2 of each slice; SEW=32, byte 0 of each slice.
REQ-022 No carry SHALL propagate between slices or between elements.
REQ-023 Add SHALL compute vs2 + vs1 per element with operation carry-in 0, modulo 2^SEW.
REQ-024 Subtract SHALL compute vs2 - vs1 per element as vs2 + ~vs1 with operation carry-in 1, modulo 2^SEW.
REQ-025 carry_o bit of the most significant byte of each element SHALL be that element's final carry-out (for subtract: 1 = no borrow); all other carry_o bits SHALL be 0.
REQ-026 Slice counter SHALL run 0..VLEN/32-1; after processing slice VLEN/32-1, state SHALL go to DONE.
REQ-027 Latency: done_o SHALL assert exactly VLEN/32 + 1 cycles after the accept edge (5 cycles for VLEN=128).
REQ-028 DONE SHALL last one cycle with done_o=1, then return to IDLE; back-to-back start_i is accepted in the IDLE cycle after DONE.
REQ-029 result_o and carry_o SHALL hold their final values from DONE until slice 0 of the next operation is written.
REQ-030 Partially written results during BUSY are not valid; only the done_o cycle qualifies them.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, slice counter 0, ready_o 1, done_o 0, result_o 0, carry_o 0, operand registers 0.
REQ-032 Reset during BUSY or DONE SHALL abort the operation; no done_o SHALL be produced for it.
REQ-033 First start_i SHALL be accepted on the first rising edge with rst_n high.

Verification
REQ-034 SEW=8 add, all bytes vs2=0xFF, vs1=0x01 -> result_o all 0x00, carry_o all ones, done_o at cycle 5.
REQ-035 SEW=16 sub, every element vs2=0x0000, vs1=0x0001 -> every element 0xFFFF, carry_o bits of the most significant byte of each element 0, all others 0.
REQ-036 SEW=32 add, elements vs2=0x0000FFFF, vs1=0x00000001 -> 0x00010000 (intra-element carry), carry_o all 0; same operands with SEW=8 -> 0x0000FF00 per element.
REQ-037 start_i held high continuously -> accepts every 6th cycle, single done_o pulse per operation, ready_o low throughout BUSY/DONE.
REQ-038 rst_n pulsed low at BUSY cycle 2 -> outputs 0, ready_o 1 asynchronously; no done_o; new op after release completes correctly.
REQ-039 sew_i=11 with SEW=32 vectors -> results identical to sew_i=10.
